maze_reader: RTL and testbench
==============================

Name: maze_reader

Overview:
- Reads a completed carved maze bitmap (1 bit per cell, 1 = open path, 0 = wall, cell index = x + MAZE_W*y).
- Snapshots the bitmap, then streams one tile per handshake in row-major order (x fastest) to a downstream consumer such as the tile renderer or player-collision logic.
- Counts open cells and flags completion, so the consumer never reads the live bitmap while it is being carved.

Parameters:
- MAZE_W, 16, maze width in cells (power of 2)
- MAZE_H, 16, maze height in cells (power of 2)
- XW, 4, width of tile_x (= log2(MAZE_W))
- YW, 4, width of tile_y (= log2(MAZE_H))

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a read pass; sampled only in IDLE
- maze_valid  input  1  bitmap complete and stable (driven by the carver's finish flag)
- maze_data  input  MAZE_W*MAZE_H  carved bitmap, bit[x + MAZE_W*y]
- tile_valid  output  1  tile_x/tile_y/tile_open/tile_last hold a valid tile
- tile_ready  input  1  consumer accepts the tile when tile_valid && tile_ready
- tile_x  output  XW  column of the current tile
- tile_y  output  YW  row of the current tile
- tile_open  output  1  snapshot bit for (tile_x, tile_y)
- tile_last  output  1  high with the final tile (MAZE_W-1, MAZE_H-1)
- busy  output  1  high in WAIT_VALID and STREAM
- done  output  1  one-cycle pulse after the last tile is accepted
- open_count  output  log2(MAZE_W*MAZE_H)+1  open tiles accepted in the last pass (9 bits at the defaults)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, tile_valid=0, tile_x=0, tile_y=0, tile_open=0, tile_last=0, busy=0, done=0, open_count=0, snapshot=0. Reset mid-stream abandons the pass; no done pulse follows.
- States: IDLE, WAIT_VALID, STREAM, DONE.
- IDLE:
  - start=1 and maze_valid=1 at an edge: capture maze_data into the snapshot, set x=y=0, clear open_count, go to STREAM.
  - start=1 and maze_valid=0: go to WAIT_VALID.
  - Otherwise stay in IDLE.
- WAIT_VALID: at the first edge with maze_valid=1, perform the same capture and go to STREAM. start is ignored in this state.
- Latency: tile_valid rises in the cycle after the capturing edge. The first tile is (0,0) with tile_open = snapshot[0].
- STREAM handshake:
  - tile_valid stays 1.
  - tile_x/tile_y/tile_open/tile_last must not change while tile_valid && !tile_ready.
  - On an edge with tile_ready=1 (transfer): open_count += tile_open, then advance.
  - Advance: x+1; when x=MAZE_W-1, x wraps to 0 and y increments.
  - tile_open is always snapshot[x + MAZE_W*y] for the presented coordinates.
- tile_last = (x==MAZE_W-1 && y==MAZE_H-1).
  - Transfer with tile_last=1: tile_valid drops at that edge, go to DONE.
  - Coordinates do not wrap past the last tile.
- DONE: lasts one cycle with done=1, then returns to IDLE. open_count holds its value until the next capture.
- busy = 1 in WAIT_VALID and STREAM, 0 in IDLE and DONE.
- Live input: changes to maze_data or maze_valid after capture have no effect on the current pass (snapshot only).
- Simultaneous events: start during STREAM or DONE is ignored (not queued). A start in the same cycle that DONE returns to IDLE is not seen; start must be high while in IDLE.
- Counting width: open_count saturates naturally at MAZE_W*MAZE_H (256), so no overflow is possible.
- Throughput: 1 tile/cycle with tile_ready held high, giving 256 transfer cycles per pass at the defaults.

Decomposition:
- Package maze_pkg:
  - MAZE_W/MAZE_H defaults.
  - Cell encoding constants CELL_WALL=1'b0, CELL_PATH=1'b1.
  - Index helper cell_idx(x,y) = x + MAZE_W*y.
  - The reader state enum.
- Sub-module maze_xy_counter:
  - Inputs: clk, rst, clear, advance.
  - Outputs: x, y, last, implementing the wrap logic.
- The FSM, snapshot register and open_count remain in maze_reader.

Test Plan:
- All-wall bitmap (maze_data=0), maze_valid=1, pulse start, tile_ready=1 → 256 transfers with tile_open=0, tile_last only at (15,15), done pulse, open_count=0.
- All-open bitmap → open_count=256. The first tile (0,0) appears exactly 1 cycle after the start edge, and tile_last/done follow 256 transfers later.
- Single open cell at bit 4+16*4=68 → only the tile at (4,4) has tile_open=1; open_count=1.
- start with maze_valid=0, then maze_valid raised 5 cycles later → busy=1 throughout, capture on the first maze_valid=1 edge, stream matches the bitmap at that edge.
- Random tile_ready backpressure plus maze_data changed mid-stream → held outputs stable during stalls, tile order unchanged, stream equals the original snapshot.
- Assert rst at tile 100 → all outputs go to reset values immediately, no done pulse. A subsequent start restarts from (0,0).

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared maze defaults, cell encoding, cell index helper and reader states
package maze_pkg;
  localparam int DEF_MAZE_W = 16;
  localparam int DEF_MAZE_H = 16;
  localparam logic CELL_WALL = 1'b0;
  localparam logic CELL_PATH = 1'b1;
  typedef enum logic [1:0] {IDLE, WAIT_VALID, STREAM, DONE} rd_state_e;
  function automatic int cell_idx(input int x, input int y, input int w = DEF_MAZE_W);
    return x + w * y;
  endfunction
endpackage

// File: rtl/maze_xy_counter.sv
// maze_xy_counter: row-major tile coordinate walker, x fastest, stops on the final tile
module maze_xy_counter #(
  parameter int XW = 4,
  parameter int YW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic [XW-1:0] x_d, x_q;
  logic [YW-1:0] y_d, y_q;
  logic          step;
  assign last = &x_q && &y_q;
  assign x    = x_q;
  assign y    = y_q;
  // power-of-2 dimensions let x wrap on its own; y bumps when x was all ones
  always_comb begin
    step = advance && !last;
    x_d  = clear ? '0 : step ? x_q + 1'b1 : x_q;
    y_d  = clear ? '0 : (step && &x_q) ? y_q + 1'b1 : y_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
endmodule

// File: rtl/maze_reader.sv
// maze_reader: snapshots a finished maze bitmap and streams it one tile per handshake
module maze_reader import maze_pkg::*; #(
  parameter int MAZE_W = DEF_MAZE_W,
  parameter int MAZE_H = DEF_MAZE_H,
  parameter int XW = 4,
  parameter int YW = 4,
  localparam int N = MAZE_W * MAZE_H,
  localparam int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          maze_valid,
  input  logic [N-1:0]  maze_data,
  output logic          tile_valid,
  input  logic          tile_ready,
  output logic [XW-1:0] tile_x,
  output logic [YW-1:0] tile_y,
  output logic          tile_open,
  output logic          tile_last,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] open_count
);
  localparam int IW = $clog2(N);
  rd_state_e     state_d, state_q;
  logic [N-1:0]  snap_d, snap_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic          valid_d, valid_q, busy_d, busy_q, done_d, done_q;
  logic          capture, xfer, last;
  logic [IW-1:0] idx;
  maze_xy_counter #(.XW(XW), .YW(YW)) u_xy (
    .clk(clk), .rst(rst), .clear(capture), .advance(xfer),
    .x(tile_x), .y(tile_y), .last(last)
  );
  assign idx        = IW'(cell_idx(int'(tile_x), int'(tile_y), MAZE_W));
  assign tile_open  = snap_q[idx];
  assign tile_last  = last;
  assign tile_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign open_count = cnt_q;
  always_comb begin
    capture = maze_valid && (state_q == WAIT_VALID || (state_q == IDLE && start));
    xfer    = state_q == STREAM && tile_ready;
    snap_d  = capture ? maze_data : snap_q;
    cnt_d   = capture ? '0 : xfer ? cnt_q + CW'(tile_open == CELL_PATH) : cnt_q;
    done_d  = xfer && last;
    valid_d = capture || (valid_q && !done_d);
    state_d = capture ? STREAM : done_d ? DONE : state_q == DONE ? IDLE :
              (state_q == IDLE && start) ? WAIT_VALID : state_q;
    busy_d  = state_d == WAIT_VALID || state_d == STREAM;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      snap_q  <= {N{CELL_WALL}};
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_maze_reader.sv
// tb_maze_reader: directed passes with a tile scoreboard and a decoupled monitor
module tb_maze_reader;
  localparam int N = 256;
  logic         clk = 0, rst = 1, start = 0, maze_valid = 0, tile_ready = 0;
  logic [N-1:0] maze_data = '0;
  logic         tile_valid, tile_open, tile_last, busy, done;
  logic [3:0]   tile_x, tile_y;
  logic [8:0]   open_count;
  int           checks = 0, failures = 0, acc = 0;
  logic [9:0]   exp_q[$];
  int           cnt_q[$];
  logic         stall_prev = 0;
  logic [9:0]   held, cur;
  logic [N-1:0] d;

  always #5 clk = ~clk;

  maze_reader dut (
    .clk(clk), .rst(rst), .start(start), .maze_valid(maze_valid), .maze_data(maze_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_x(tile_x), .tile_y(tile_y),
    .tile_open(tile_open), .tile_last(tile_last), .busy(busy), .done(done),
    .open_count(open_count)
  );

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset();
    chk("rst_valid", tile_valid, 0);
    chk("rst_x", tile_x, 0);
    chk("rst_y", tile_y, 0);
    chk("rst_open", tile_open, 0);
    chk("rst_last", tile_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", open_count, 0);
  endtask

  // monitor: pops the scoreboard on every transfer, checks holds during stalls and done pulses
  always @(negedge clk) begin
    cur = {tile_x, tile_y, tile_open, tile_last};
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev && tile_valid) chk("hold", cur, held);
      if (tile_valid && tile_ready) begin
        if (exp_q.size() == 0) chk("extra_tile", 1, 0);
        else chk("tile", cur, exp_q.pop_front());
        acc++;
      end
      if (done) begin
        if (cnt_q.size() == 0) chk("spurious_done", 1, 0);
        else chk("open_count", open_count, cnt_q.pop_front());
      end
      stall_prev = tile_valid && !tile_ready;
      held = cur;
    end
  end

  task automatic run_pass(input logic [N-1:0] data, input int wait_cyc, input bit rnd, input int reset_at);
    int a0;
    bit seen;
    seen = 0;
    for (int i = 0; i < N; i++) exp_q.push_back({4'(i % 16), 4'(i / 16), data[i], i == N - 1});
    cnt_q.push_back($countones(data));
    maze_valid = wait_cyc == 0;
    maze_data  = wait_cyc == 0 ? data : ~data;
    tile_ready = 1;
    start      = 1;
    a0         = acc;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < wait_cyc; c++) begin
      chk("wait_busy", busy, 1);
      chk("wait_no_valid", tile_valid, 0);
      if (c == wait_cyc - 1) begin
        maze_valid = 1;
        maze_data  = data;
      end
      @(posedge clk); #1;
    end
    chk("first_valid", tile_valid, 1);
    chk("first_xy", {tile_x, tile_y}, 0);
    chk("stream_busy", busy, 1);
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (rnd) begin
        tile_ready = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
      end
      if (c == 20) begin
        maze_data  = ~data;
        maze_valid = 0;
      end
      if (reset_at >= 0 && acc - a0 >= reset_at) begin
        rst = 1;
        #1;
        check_reset();
        exp_q.delete();
        cnt_q.delete();
        @(posedge clk); #1;
        rst = 0;
        maze_valid = 1;
        return;
      end
      @(posedge clk); #1;
      if (done) begin
        seen  = 1;
        start = 0;
        chk("done_busy", busy, 0);
        chk("done_valid", tile_valid, 0);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    maze_valid = 1;
    @(posedge clk); #1;
    chk("idle_done_low", done, 0);
    chk("pass_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    rst = 0;
    @(posedge clk); #1;
    chk("idle_no_valid", tile_valid, 0);
    run_pass('0, 0, 0, -1);
    run_pass('1, 0, 0, -1);
    d = '0;
    d[68] = 1;
    run_pass(d, 0, 0, -1);
    d = {8{32'hA5C3_0F1E}};
    run_pass(d, 5, 0, -1);
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    run_pass(d, 0, 1, -1);
    d = {8{32'h1234_F00D}};
    run_pass(d, 0, 0, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", tile_valid, 0);
    chk("post_rst_busy", busy, 0);
    run_pass(d, 0, 0, -1);
    chk("final_queue", exp_q.size() + cnt_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
